// File: rtl/mux16_rr_sched_if.sv
// Bundle between the 16 source channels / serial consumer and the round-robin scheduler.
// master is the scheduler side, slave is the environment (sources plus consumer).
interface mux16_rr_sched_if;
    localparam int unsigned N_CH  = 16;
    localparam int unsigned SEL_W = 4;

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  din;
    logic             out_ready;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  gnt;
    logic             out_valid;
    logic             y;
    logic             busy;

    modport master (
        input  req, din, out_ready,
        output sel, gnt, out_valid, y, busy
    );

    modport slave (
        output req, din, out_ready,
        input  sel, gnt, out_valid, y, busy
    );
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 bit mux between 16 requesters,
// with bounded bursts per grant and a valid/ready output toward one consumer.
module mux16_rr_sched #(
    parameter int unsigned MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux16_rr_sched_if.master bus
);
    localparam int unsigned N_CH  = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W:0]   pick_idle;
    logic [SEL_W:0]   pick_rel;
    logic             xfer;
    logic             release_c;

    // First requester at or after start (mod 16); MSB flags that one was found.
    function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] start,
                                               input logic [N_CH-1:0]  r);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = start + SEL_W'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    assign pick_idle = rr_pick(ptr_q, bus.req);
    assign pick_rel  = rr_pick(sel_q + SEL_W'(1), bus.req);
    assign xfer      = valid_q & bus.out_ready;
    // Abandon and last-bit both show up as req[sel] low; the burst limit needs an accepted transfer.
    assign release_c = !bus.req[sel_q] || (xfer && (cnt_q == BURST_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_idle[SEL_W]) begin
                    state_d = GRANT;
                    sel_d   = pick_idle[SEL_W-1:0];
                    gnt_d   = N_CH'(1) << pick_idle[SEL_W-1:0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = sel_q + SEL_W'(1);
                    cnt_d = '0;
                    // Re-arbitrate in the same edge so consecutive grants have no bubble.
                    if (pick_rel[SEL_W]) begin
                        sel_d = pick_rel[SEL_W-1:0];
                        gnt_d = N_CH'(1) << pick_rel[SEL_W-1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.y         = valid_q & bus.din[sel_q];

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: one instance with MAX_BURST=4 and one with MAX_BURST=1.
module tb_mux16_rr_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   inv_en;

    mux16_rr_sched_if i4 ();
    mux16_rr_sched_if i1 ();

    mux16_rr_sched #(.MAX_BURST(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.master));
    mux16_rr_sched #(.MAX_BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            check("inv4_onehot", 32'($onehot0(i4.gnt)), 32'd1);
            check("inv4_valid_busy", 32'(i4.out_valid), 32'(i4.busy));
            if (i4.busy) check("inv4_gnt_sel", 32'(i4.gnt), 32'(16'd1 << i4.sel));
            check("inv1_onehot", 32'($onehot0(i1.gnt)), 32'd1);
            check("inv1_valid_busy", 32'(i1.out_valid), 32'(i1.busy));
            if (i1.busy) check("inv1_gnt_sel", 32'(i1.gnt), 32'(16'd1 << i1.sel));
        end
    end

    logic [3:0] burst_exp [12];
    bit         y_seq     [16];

    initial begin
        checks    = 0;
        errors    = 0;
        inv_en    = 1'b0;
        burst_exp = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd4, 4'd4, 4'd4, 4'd4};
        y_seq     = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};

        rst_n        = 1'b0;
        i4.req       = 16'hFFFF;
        i4.din       = 16'h0000;
        i4.out_ready = 1'b0;
        i1.req       = 16'h0000;
        i1.din       = 16'hA5A5;
        i1.out_ready = 1'b1;

        // Reset with every channel requesting
        tick();
        tick();
        check("rst_sel", 32'(i4.sel), 32'd0);
        check("rst_gnt", 32'(i4.gnt), 32'd0);
        check("rst_valid", 32'(i4.out_valid), 32'd0);
        check("rst_y", 32'(i4.y), 32'd0);
        check("rst_busy", 32'(i4.busy), 32'd0);
        check("rst_gnt1", 32'(i1.gnt), 32'd0);
        inv_en = 1'b1;
        rst_n  = 1'b1;
        tick();
        check("post_rst_gnt", 32'(i4.gnt), 32'h0001);
        check("post_rst_sel", 32'(i4.sel), 32'd0);
        check("post_rst_valid", 32'(i4.out_valid), 32'd1);

        // Round robin 0 -> 8 -> 15 -> 0, each dropping req during its single transfer
        rst_n  = 1'b0;
        i4.req = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(i4.out_valid), 32'd0);
        i4.req       = 16'h8101;
        i4.out_ready = 1'b1;
        tick();
        check("rr_sel0", 32'(i4.sel), 32'd0);
        i4.req = 16'h8100;
        tick();
        check("rr_sel8", 32'(i4.sel), 32'd8);
        check("rr_gnt8", 32'(i4.gnt), 32'h0100);
        i4.req = 16'h8000;
        tick();
        check("rr_sel15", 32'(i4.sel), 32'd15);
        i4.req = 16'h0001;
        tick();
        check("rr_wrap_sel", 32'(i4.sel), 32'd0);
        check("rr_wrap_valid", 32'(i4.out_valid), 32'd1);
        i4.req = 16'h0000;
        tick();
        check("rr_idle_valid", 32'(i4.out_valid), 32'd0);
        check("rr_idle_gnt", 32'(i4.gnt), 32'd0);

        // Burst limit: channels 4 and 5 alternate every 4 transfers
        i4.req = 16'h0030;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("burst_sel_%0d", i), 32'(i4.sel), 32'(burst_exp[i]));
            check($sformatf("burst_valid_%0d", i), 32'(i4.out_valid), 32'd1);
        end
        i4.req = 16'h0000;
        tick();
        check("burst_idle", 32'(i4.out_valid), 32'd0);

        // Backpressure on channel 3 (ptr is 5, so 3 wins ahead of 4)
        i4.out_ready = 1'b0;
        i4.din       = 16'h0008;
        i4.req       = 16'h0018;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_sel_%0d", i), 32'(i4.sel), 32'd3);
            check($sformatf("bp_y_%0d", i), 32'(i4.y), 32'd1);
            check($sformatf("bp_valid_%0d", i), 32'(i4.out_valid), 32'd1);
            if (i < 4) tick();
        end
        i4.out_ready = 1'b1;
        tick();
        check("bp_one_xfer", 32'(i4.sel), 32'd3);
        tick();
        tick();
        check("bp_three_xfer", 32'(i4.sel), 32'd3);
        tick();
        check("bp_rotate_sel", 32'(i4.sel), 32'd4);
        check("bp_rotate_y", 32'(i4.y), 32'd0);

        // Abandon: channel 4 drops req without a transfer
        i4.out_ready = 1'b0;
        i4.req       = 16'h0408;
        tick();
        check("abandon_sel", 32'(i4.sel), 32'd10);
        check("abandon_gnt", 32'(i4.gnt), 32'h0400);

        // Reset mid-grant clears the grant and the pointer
        rst_n = 1'b0;
        tick();
        check("midrst_gnt", 32'(i4.gnt), 32'd0);
        check("midrst_busy", 32'(i4.busy), 32'd0);
        check("midrst_valid", 32'(i4.out_valid), 32'd0);
        rst_n  = 1'b1;
        i4.req = 16'h0041;
        tick();
        check("midrst_ptr", 32'(i4.sel), 32'd0);

        // Data path with MAX_BURST=1: sel steps 0..15, y follows din=A5A5
        i1.req = 16'hFFFF;
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("dp_sel_%0d", i), 32'(i1.sel), 32'(i));
            check($sformatf("dp_y_%0d", i), 32'(i1.y), 32'(y_seq[i]));
            tick();
        end
        check("dp_wrap", 32'(i1.sel), 32'd0);
        check("dp_wrap_valid", 32'(i1.out_valid), 32'd1);

        inv_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares one 16:1 single-bit mux datapath between 16 requesters.
- Arbitrates the request lines, drives the 4-bit mux select and a one-hot grant, and presents the selected input bit downstream over a valid/ready handshake.
- Limits each grant to a bounded burst so that no requester can starve the others.
- Sits between the 16 source channels and a single serial consumer.

Parameters:
- MAX_BURST, 4, maximum accepted transfers per grant before forced rotation (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  16  request lines; req[k] high means channel k has data.
- din  input  16  data bits; din[k] is channel k's mux input.
- out_ready  input  1  downstream consumer accepts y this cycle.
- sel  output  4  mux select driven to the datapath; index of the granted channel.
- gnt  output  16  one-hot grant; all zero when idle.
- out_valid  output  1  y is valid and a transfer is offered.
- y  output  1  combinational: din[sel] when out_valid, else 0.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (rst_n low at a rising edge) forces:
  - state=IDLE, sel=0, gnt=0, out_valid=0, busy=0.
  - rotation pointer ptr=0, burst_cnt=0.
  - y therefore reads 0.
- Reset asserted mid-grant aborts the grant immediately at that edge. No transfer is counted in that cycle.
- States: IDLE and GRANT. sel, gnt, out_valid and busy are registered.
- Arbitration function: pick the first k with req[k]=1, scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- IDLE:
  - If req != 0 at edge t, go to GRANT at t.
  - Load sel=k, gnt=1<<k, out_valid=1, burst_cnt=0.
  - Grant is visible in cycle t+1, so request-to-grant latency is 1 cycle.
  - If req == 0, stay in IDLE.
- GRANT, transfer accepted (out_valid & out_ready):
  - burst_cnt increments.
  - Release the grant if either:
    - req[sel] is 0 in the same cycle (last bit), or
    - burst_cnt == MAX_BURST-1 (burst limit reached).
- GRANT, requester abandons (req[sel]=0 with no transfer): release at that edge. Nothing is counted.
- GRANT, otherwise: hold sel, gnt, out_valid and burst_cnt. sel must not change while out_valid=1 and out_ready=0.
- On release:
  - ptr = sel+1 (4-bit wrap, so 15 goes to 0).
  - Arbitrate immediately using the new ptr and the current req, excluding the releasing channel only when its req is 0.
  - If a winner exists, go to GRANT with the new sel and burst_cnt=0. There is no idle bubble, so back-to-back grants occur on consecutive cycles.
  - If there is no winner, go to IDLE and clear out_valid and gnt.
- Sole requester hitting MAX_BURST: the scan wraps back to it, so it is re-granted with no bubble and burst_cnt is cleared.
- Invariants (bench asserts every cycle):
  - gnt is zero or one-hot.
  - gnt == 1<<sel whenever busy.
  - out_valid == busy.
- Throughput: one transfer per cycle while out_ready=1 and requests persist.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with req=16'hFFFF → sel=0, gnt=0, out_valid=0, y=0. Release reset → next cycle gnt=16'h0001, sel=0.
- Round-robin: req=16'h8101, out_ready=1, each requester drops req after 1 transfer → grant order 0, 8, 15. Then with req=16'h0001 re-raised the wrap is 15→0, giving sel=0 again with no idle cycle between grants.
- Burst limit (MAX_BURST=4): req=16'h0030 held high, out_ready=1 → sel=4 for 4 transfers, then sel=5 for 4, then 4 again. Exactly 4 consecutive valid cycles per grant.
- Backpressure: grant on channel 3 with din=16'h0008, out_ready=0 for 5 cycles → sel=3, y=1, out_valid=1 stable and burst_cnt unchanged. Raise out_ready → one transfer counted.
- Data path: din=16'hA5A5, req=16'hFFFF, out_ready=1, MAX_BURST=1 → sel steps 0..15 one per cycle. y sequence matches din bits 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1.
- Abandon and reset mid-grant:
  - Drop req[sel] with out_ready=0 → next cycle the grant moves to the next requester and ptr advances.
  - Assert rst_n=0 during GRANT → the following cycle gnt=0 and ptr=0.
